// File: rtl/ldpc_flip_ctrl.sv
// Iterative bit-flip decode controller for the 6-bit LDPC decoder.
// Works the latched word through syndrome/flip rounds and hands the result downstream.
module ldpc_flip_ctrl #(
  parameter int W        = 6,
  parameter int MAX_ITER = 4,
  parameter int ITER_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      cw_in,
  input  logic [W-1:0]      c1_in,
  input  logic [W-1:0]      c2_in,
  input  logic [W-1:0]      c3_in,
  output logic [W-1:0]      c1,
  output logic [W-1:0]      c2,
  output logic [W-1:0]      c3,
  output logic [2:0]        sy,
  input  logic [W-1:0]      v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      cw_out,
  output logic              dec_ok,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {IDLE, SYND, WAIT, FLIP, DONE} state_t;

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  state_t       state;
  state_t       state_nx;
  logic [2:0]   syn_calc;
  logic [W-1:0] mask;

  assign syn_calc  = {^(cw_out & c1), ^(cw_out & c2), ^(cw_out & c3)};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Weight-2 syndromes trust the checker's votes; other patterns use only the row overlap
  always_comb begin
    mask = '0;
    case (sy)
      3'b110:  mask = v & c1 & c2;
      3'b101:  mask = v & c1 & c3;
      3'b011:  mask = v & c2 & c3;
      3'b100:  mask = c1 & ~c2 & ~c3;
      3'b010:  mask = c2 & ~c1 & ~c3;
      3'b001:  mask = c3 & ~c1 & ~c2;
      3'b111:  mask = c1 & c2 & c3;
      default: mask = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = SYND;
      SYND: begin
        if (syn_calc == 3'b000)      state_nx = DONE;
        else if (iter_cnt == MAX_CNT) state_nx = DONE;
        else                          state_nx = WAIT;
      end
      WAIT: state_nx = FLIP;
      FLIP: state_nx = (mask == '0) ? DONE : SYND;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Rows only move on accept so the flip checker sees a stable problem for the whole decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_out   <= '0;
      c1       <= '0;
      c2       <= '0;
      c3       <= '0;
      sy       <= '0;
      iter_cnt <= '0;
      dec_ok   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cw_out   <= cw_in;
            c1       <= c1_in;
            c2       <= c2_in;
            c3       <= c3_in;
            iter_cnt <= '0;
            dec_ok   <= 1'b0;
          end
        end
        SYND: begin
          sy     <= syn_calc;
          dec_ok <= (syn_calc == 3'b000);
        end
        FLIP: begin
          if (mask != '0) begin
            cw_out <= cw_out ^ mask;
            if (iter_cnt != MAX_CNT) iter_cnt <= iter_cnt + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ldpc_flip_ctrl.md
Name: ldpc_flip_ctrl

Overview:
- Iterative bit-flip decode controller for the 6-bit LDPC decoder.
- Accepts a received word and latches the three parity-check rows.
- Computes the 3-bit syndrome and drives it, with the latched rows, to the flip checker stage.
- Consumes the flip checker's vote vector v, applies the flip mask to the working word, and repeats until the syndrome is zero or the iteration limit is reached; then presents the result with valid/ready.

Parameters:
- W, 6: codeword width; flip checker interface is 6 bits, so only 6 is supported.
- MAX_ITER, 4: maximum flip iterations before declaring failure; 0 is legal (detect-only).
- ITER_W, 3: width of the iteration counter; must hold MAX_ITER.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  high only in IDLE.
- cw_in  in  W  received codeword.
- c1_in,c2_in,c3_in  in  W  parity-check rows; sampled on accept.
- c1,c2,c3  out  W  latched rows, to flip checker.
- sy  out  3  registered syndrome to flip checker: sy[2]=row c1, sy[1]=row c2, sy[0]=row c3.
- v  in  W  flip checker vote vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- cw_out  out  W  decoded word (working register).
- dec_ok  out  1  1 = final syndrome zero.
- iter_cnt  out  ITER_W  flip iterations performed.

Behaviour:
- Reset (async, immediate): state=IDLE; sy, c1..c3, cw_out, iter_cnt = 0; out_valid=0, dec_ok=0, in_ready=1.
- IDLE:
  - in_ready=1.
  - On in_valid: latch cw_in into working word and c*_in into c1..c3; iter_cnt=0; go to SYND.
- SYND:
  - sy[2]=^(cw&c1), sy[1]=^(cw&c2), sy[0]=^(cw&c3), registered this edge.
  - If the computed value is 0: DONE, dec_ok=1.
  - Else if iter_cnt==MAX_ITER: DONE, dec_ok=0.
  - Else: go to WAIT.
- WAIT:
  - One full cycle with sy and c1..c3 stable so the flip checker, which evaluates on both clock edges, settles.
  - Go to FLIP.
- FLIP: form the mask from the current sy:
  - 110 -> v&c1&c2
  - 101 -> v&c1&c3
  - 011 -> v&c2&c3
  - 100 -> c1&~c2&~c3
  - 010 -> c2&~c1&~c3
  - 001 -> c3&~c1&~c2
  - 111 -> c1&c2&c3
  - For weight-1 and 111 syndromes, v is ignored because the flip checker does not update it.
  - If mask==0: DONE, dec_ok=0, no flip.
  - Else: cw ^= mask, iter_cnt+1, go to SYND.
- DONE:
  - out_valid=1; cw_out, dec_ok and iter_cnt held stable.
  - On out_ready: out_valid=0, go to IDLE. Accepting a new word takes a further cycle; no same-cycle turnaround.
- Latency from the accept edge:
  - Clean word: out_valid at +2.
  - Each flip iteration adds 3 cycles (SYND→WAIT→FLIP).
- Stability:
  - c1..c3 change only on accept.
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
- iter_cnt saturates at MAX_ITER and never wraps.
- Reset asserted mid-decode: all state is discarded; no out_valid is produced for the aborted word.

Test Plan:
- Common setup: rows c1_in=001011, c2_in=010101, c3_in=100110.
- Clean word: cw_in=000000 -> sy=000; out_valid at +2; cw_out=000000, dec_ok=1, iter_cnt=0.
- Single error, weight-2 syndrome (uses v): cw_in=000001 -> sy=110; flip checker v applied; cw_out=000000, dec_ok=1, iter_cnt=1, out_valid at +5. Repeat for cw_in=000010 (sy=101) and 000100 (sy=011).
- Single error, weight-1 syndrome: cw_in=001000, 010000, 100000 -> sy=100/010/001; bench forces v=111111 (must be ignored); cw_out=000000, dec_ok=1, iter_cnt=1.
- Uncorrectable and detect-only:
  - cw_in=111000 -> sy=111, mask=000000 -> out_valid at +4, dec_ok=0, iter_cnt=0, cw_out=111000.
  - With MAX_ITER=0, cw_in=000001 -> out_valid at +2, dec_ok=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-op: assert rst during WAIT -> outputs reset immediately without a clock edge; after release, cw_in=000001 decodes normally to 000000.
